// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared types and default 720p raster geometry for the video timing blocks
//   (pixel_iterator on the transmit side, video_timing_decoder on the receive side).
//   No ports.
package video_timing_pkg;

  // Lock state machine of the decoder.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vtd_state_t;

  // Default 1280x720p60 timing.
  localparam int   DEF_HOR_TOTAL_PIXELS  = 1650;
  localparam int   DEF_HOR_ACTIVE_PIXELS = 1280;
  localparam logic DEF_HOR_SYNC_POLARITY = 1'b1;
  localparam int   DEF_VER_TOTAL_PIXELS  = 750;
  localparam int   DEF_VER_ACTIVE_PIXELS = 720;
  localparam logic DEF_VER_SYNC_POLARITY = 1'b1;
  localparam int   DEF_LOCK_FRAMES       = 2;

endpackage

// File: rtl/sync_edge_detector.sv
// sync_edge_detector
//   Two-stage sampler for one raster control signal. Stage 1 captures the
//   input normalised so that 1 means "asserted"; stage 2 is stage 1 delayed
//   by one enabled cycle. Edges are stage 1 versus stage 2.
// Ports
//   clk_rgb  in   pixel clock
//   rst      in   synchronous active-high reset (both stages clear to deasserted)
//   ce       in   clock enable, low freezes both stages
//   sig_i    in   raw input signal
//   level_o  out  normalised stage-1 level
//   rise_o   out  asserting edge (stage1 & ~stage2)
//   fall_o   out  deasserting edge (~stage1 & stage2)
module sync_edge_detector #(
  parameter logic POLARITY = 1'b1
) (
  input  logic clk_rgb,
  input  logic rst,
  input  logic ce,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else if (ce) begin
      s1_q <= (sig_i == POLARITY);
      s2_q <= s1_q;
    end
  end

  assign level_o = s1_q;
  assign rise_o  = s1_q & ~s2_q;
  assign fall_o  = ~s1_q & s2_q;

endmodule

// File: rtl/video_timing_decoder.sv
// video_timing_decoder
//   Receive-side raster decoder: recovers x/y pixel coordinates and line/frame
//   strobes from an hs/vs/de stream, measures line and frame geometry, and
//   declares lock after LOCK_FRAMES consecutive clean frames.
//   Optional build macro VIDEO_TIMING_DECODER_ERR_CNT_EN adds err_count.
// Ports
//   clk_rgb, rst, ce     pixel clock, sync active-high reset, clock enable
//   hs, vs, de           incoming raster (hs/vs polarity set by parameters)
//   x, y, active         recovered coordinates, valid while active
//   frame_start          1-cycle pulse on vs asserting edge
//   line_start           1-cycle pulse on hs asserting edge
//   hor_total            last measured line length in clocks
//   ver_total            last measured frame length in lines
//   locked               geometry matched for LOCK_FRAMES frames
//   mismatch             1-cycle pulse on any geometry violation
//   err_count            (macro only) saturating count of mismatch pulses
// All outputs are registered; input-to-output latency is 2 enabled cycles.
module video_timing_decoder
  import video_timing_pkg::*;
#(
  parameter int   HOR_TOTAL_PIXELS  = DEF_HOR_TOTAL_PIXELS,
  parameter int   HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
  parameter logic HOR_SYNC_POLARITY = DEF_HOR_SYNC_POLARITY,
  parameter int   VER_TOTAL_PIXELS  = DEF_VER_TOTAL_PIXELS,
  parameter int   VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
  parameter logic VER_SYNC_POLARITY = DEF_VER_SYNC_POLARITY,
  parameter int   LOCK_FRAMES       = DEF_LOCK_FRAMES,
  localparam int  X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int  Y_WIDTH = $clog2(VER_ACTIVE_PIXELS),
  localparam int  HT_W    = $clog2(HOR_TOTAL_PIXELS + 1),
  localparam int  VT_W    = $clog2(VER_TOTAL_PIXELS + 1)
) (
  input  logic               clk_rgb,
  input  logic               rst,
  input  logic               ce,
  input  logic               hs,
  input  logic               vs,
  input  logic               de,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               active,
  output logic               frame_start,
  output logic               line_start,
  output logic [HT_W-1:0]    hor_total,
  output logic [VT_W-1:0]    ver_total,
  output logic               locked,
  output logic               mismatch
`ifdef VIDEO_TIMING_DECODER_ERR_CNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);

  localparam logic [HT_W-1:0]    HSAT    = '1;
  localparam logic [HT_W-1:0]    HSAT_M1 = HSAT - 1'b1;
  localparam logic [VT_W-1:0]    VSAT    = '1;
  localparam logic [HT_W-1:0]    HT_L    = HT_W'(HOR_TOTAL_PIXELS);
  localparam logic [HT_W-1:0]    HA_L    = HT_W'(HOR_ACTIVE_PIXELS);
  localparam logic [VT_W-1:0]    VT_L    = VT_W'(VER_TOTAL_PIXELS);
  localparam logic [VT_W-1:0]    VA_L    = VT_W'(VER_ACTIVE_PIXELS);
  localparam logic [Y_WIDTH-1:0] Y_LAST  = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);

  // ---------------- input stage ----------------
  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic de_lvl, de_rise, de_fall;

  sync_edge_detector #(.POLARITY(HOR_SYNC_POLARITY)) u_hs (
    .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .sig_i(hs),
    .level_o(hs_lvl), .rise_o(hs_rise), .fall_o(hs_fall));
  sync_edge_detector #(.POLARITY(VER_SYNC_POLARITY)) u_vs (
    .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .sig_i(vs),
    .level_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall));
  sync_edge_detector #(.POLARITY(1'b1)) u_de (
    .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .sig_i(de),
    .level_o(de_lvl), .rise_o(de_rise), .fall_o(de_fall));

  logic unused_edges;
  assign unused_edges = ^{hs_lvl, hs_fall, vs_lvl, vs_fall};

  // ---------------- state ----------------
  logic [HT_W-1:0]    hcnt_q, hcnt_d, acnt_q, acnt_d, hor_total_q, hor_total_d, hlen;
  logic [VT_W-1:0]    vcnt_q, vcnt_d, alcnt_q, alcnt_d, ver_total_q, ver_total_d, alines;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               active_q, line_start_q, frame_start_q, mismatch_q, locked_q;
  logic               skip_q;
  logic [MW-1:0]      match_q;
  vtd_state_t         state_q;
  logic               line_err, frame_err, sat_err, err, chk_en;

  // Line checks are off in SEARCH and for the first line after leaving it,
  // since that line may have started before measurement began.
  assign chk_en = (state_q != SEARCH) && !skip_q;

  always_comb begin
    hcnt_d      = hcnt_q;
    acnt_d      = acnt_q;
    hor_total_d = hor_total_q;
    vcnt_d      = vcnt_q;
    alcnt_d     = alcnt_q;
    ver_total_d = ver_total_q;
    x_d         = x_q;
    y_d         = y_q;
    line_err    = 1'b0;
    frame_err   = 1'b0;
    sat_err     = 1'b0;
    // Line length counts the edge cycle itself, hence hcnt+1.
    hlen   = (hcnt_q == HSAT) ? HSAT : hcnt_q + 1'b1;
    // Active-line count including a de fall landing on this very cycle.
    alines = (de_fall && alcnt_q != VSAT) ? alcnt_q + 1'b1 : alcnt_q;

    if (hs_rise) begin
      hcnt_d      = '0;
      hor_total_d = hlen;
      acnt_d      = de_lvl ? HT_W'(1) : '0;
      line_err    = chk_en && ((hlen != HT_L) || (acnt_q != '0 && acnt_q != HA_L));
    end else begin
      hcnt_d  = hlen;
      // Fires once, on the step into saturation.
      sat_err = (hcnt_q == HSAT_M1);
      if (de_lvl && acnt_q != HSAT) acnt_d = acnt_q + 1'b1;
    end

    if (vs_rise) begin
      vcnt_d      = '0;
      alcnt_d     = '0;
      ver_total_d = vcnt_q;
      frame_err   = (state_q != SEARCH) && ((vcnt_q != VT_L) || (alines != VA_L));
    end else begin
      if (hs_rise && vcnt_q != VSAT) vcnt_d = vcnt_q + 1'b1;
      alcnt_d = alines;
    end

    if (de_rise)     x_d = '0;
    else if (de_lvl) x_d = x_q + 1'b1;

    if (vs_rise)                      y_d = '0;
    else if (de_fall && y_q != Y_LAST) y_d = y_q + 1'b1;
  end

  assign err = line_err | frame_err | sat_err;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      hcnt_q        <= '0;
      acnt_q        <= '0;
      hor_total_q   <= '0;
      vcnt_q        <= '0;
      alcnt_q       <= '0;
      ver_total_q   <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (ce) begin
      hcnt_q        <= hcnt_d;
      acnt_q        <= acnt_d;
      hor_total_q   <= hor_total_d;
      vcnt_q        <= vcnt_d;
      alcnt_q       <= alcnt_d;
      ver_total_q   <= ver_total_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= de_lvl;
      line_start_q  <= hs_rise;
      frame_start_q <= vs_rise;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  // ---------------- lock FSM ----------------
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      state_q    <= SEARCH;
      match_q    <= '0;
      skip_q     <= 1'b1;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else if (ce) begin
      mismatch_q <= err;
      if (state_q == SEARCH || err) skip_q <= 1'b1;
      else if (hs_rise)             skip_q <= 1'b0;
      if (err) begin
        state_q  <= SEARCH;
        match_q  <= '0;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          SEARCH: if (vs_rise) begin
            state_q <= MEASURE;
            match_q <= '0;
          end
          MEASURE: if (vs_rise) begin
            match_q <= match_q + 1'b1;
            if (int'(match_q) + 1 >= LOCK_FRAMES) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: ;
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end else begin
      mismatch_q <= 1'b0;
    end
  end

`ifdef VIDEO_TIMING_DECODER_ERR_CNT_EN
  logic [15:0] err_count_q;
  always_ff @(posedge clk_rgb) begin
    if (rst)                                    err_count_q <= '0;
    else if (ce && err && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 1'b1;
  end
  assign err_count = err_count_q;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign hor_total   = hor_total_q;
  assign ver_total   = ver_total_q;
  assign locked      = locked_q;
  assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder on a reduced raster (20x10 total,
// 12x6 active). Instance u0 uses active-high syncs, u1 the inverted polarity
// with inverted hs/vs stimulus; both must behave identically.
module tb_video_timing_decoder;
  localparam int HT = 20, HA = 12, HFP = 2, HSW = 3;
  localparam int VT = 10, VA = 6, VFP = 1, VSW = 2;
  localparam int LF = 2;
  localparam int XW = $clog2(HA), YW = $clog2(VA);
  localparam int HTW = $clog2(HT + 1), VTW = $clog2(VT + 1);
  localparam int GUARD = 5000;

  logic clk = 1'b0;
  logic rst, ce, hs_a, vs_a, de;
  always #5 clk = ~clk;

  logic [XW-1:0]  a_x, b_x;
  logic [YW-1:0]  a_y, b_y;
  logic           a_act, b_act, a_fs, b_fs, a_ls, b_ls, a_lk, b_lk, a_mm, b_mm;
  logic [HTW-1:0] a_ht, b_ht;
  logic [VTW-1:0] a_vt, b_vt;
`ifdef VIDEO_TIMING_DECODER_ERR_CNT_EN
  logic [15:0]    a_ec, b_ec;
`endif

  video_timing_decoder #(
    .HOR_TOTAL_PIXELS(HT), .HOR_ACTIVE_PIXELS(HA), .HOR_SYNC_POLARITY(1'b1),
    .VER_TOTAL_PIXELS(VT), .VER_ACTIVE_PIXELS(VA), .VER_SYNC_POLARITY(1'b1),
    .LOCK_FRAMES(LF)
  ) u0 (
    .clk_rgb(clk), .rst(rst), .ce(ce), .hs(hs_a), .vs(vs_a), .de(de),
    .x(a_x), .y(a_y), .active(a_act), .frame_start(a_fs), .line_start(a_ls),
    .hor_total(a_ht), .ver_total(a_vt), .locked(a_lk), .mismatch(a_mm)
`ifdef VIDEO_TIMING_DECODER_ERR_CNT_EN
    , .err_count(a_ec)
`endif
  );

  video_timing_decoder #(
    .HOR_TOTAL_PIXELS(HT), .HOR_ACTIVE_PIXELS(HA), .HOR_SYNC_POLARITY(1'b0),
    .VER_TOTAL_PIXELS(VT), .VER_ACTIVE_PIXELS(VA), .VER_SYNC_POLARITY(1'b0),
    .LOCK_FRAMES(LF)
  ) u1 (
    .clk_rgb(clk), .rst(rst), .ce(ce), .hs(~hs_a), .vs(~vs_a), .de(de),
    .x(b_x), .y(b_y), .active(b_act), .frame_start(b_fs), .line_start(b_ls),
    .hor_total(b_ht), .ver_total(b_vt), .locked(b_lk), .mismatch(b_mm)
`ifdef VIDEO_TIMING_DECODER_ERR_CNT_EN
    , .err_count(b_ec)
`endif
  );

  int n_cmp = 0, n_err = 0;
  int mm_seen = 0;
  always @(negedge clk) if (a_mm === 1'b1) mm_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raster position generator. pf/pr/pc = position driven by the last tick;
  // DUT outputs after that tick reflect the position before it.
  int frm, row, col, llen, pf, pr, pc, sf, sr;
  logic hold_hs, ce_tog;

  task automatic tick();
    de   = (col < HA) && (row < VA);
    hs_a = !hold_hs && (col >= HA + HFP) && (col < HA + HFP + HSW);
    vs_a = (row >= VA + VFP) && (row < VA + VFP + VSW);
    ce   = 1'b1;
    @(posedge clk); #1;
    if (ce_tog) begin
      ce = 1'b0;
      @(posedge clk); #1;
    end
    pf = frm; pr = row; pc = col;
    col++;
    if (col >= llen) begin
      col = 0;
      row++;
      if (row == VT) begin row = 0; frm++; end
      llen = (frm == sf && row == sr) ? HT + 1 : HT;
    end
  endtask

  task automatic run_to(input int f, input int r, input int c);
    int g = 0;
    while (!(pf == f && pr == r && pc == c) && g < GUARD) begin
      tick();
      g++;
    end
    chk("run_to_bound", 32'(g < GUARD), 32'd1);
  endtask

  task automatic restart_raster();
    frm = 0; row = 0; col = 0; llen = HT; pf = -1; pr = -1; pc = -1;
  endtask

  int mm0;

  initial begin
    rst = 1'b1; ce = 1'b1; hs_a = 1'b0; vs_a = 1'b0; de = 1'b0;
    hold_hs = 1'b0; ce_tog = 1'b0; sf = -1; sr = -1;
    restart_raster();
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_x", 32'(a_x), 0);
    chk("rst_y", 32'(a_y), 0);
    chk("rst_active", 32'(a_act), 0);
    chk("rst_hor_total", 32'(a_ht), 0);
    chk("rst_ver_total", 32'(a_vt), 0);
    chk("rst_locked", 32'(a_lk), 0);
    chk("rst_strobes", 32'({a_fs, a_ls, a_mm}), 0);
    chk("rst_inv_locked", 32'(b_lk), 0);
    rst = 1'b0;

    // lock acquisition: vs edges at frame0/1/2 row 7
    run_to(2, 7, 0);
    chk("lock_before", 32'(a_lk), 0);
    run_to(2, 7, 1);
    chk("lock_after", 32'(a_lk), 1);
    chk("lock_inv", 32'(b_lk), 1);
    chk("frame_start", 32'(a_fs), 1);
    chk("ver_total", 32'(a_vt), VT);
    chk("hor_total", 32'(a_ht), HT);
    chk("ver_total_inv", 32'(b_vt), VT);
    chk("no_mismatch", 32'(mm_seen), 0);
    run_to(2, 7, 2);
    chk("frame_start_1cyc", 32'(a_fs), 0);

    // coordinates
    run_to(3, 0, 0);
    chk("first_pix_lat", 32'(a_act), 0);
    run_to(3, 0, 1);
    chk("first_active", 32'(a_act), 1);
    chk("first_x", 32'(a_x), 0);
    chk("first_y", 32'(a_y), 0);
    chk("first_x_inv", 32'(b_x), 0);
    run_to(3, 1, 15);
    chk("line_start", 32'(a_ls), 1);
    run_to(3, 1, 16);
    chk("line_start_1cyc", 32'(a_ls), 0);
    run_to(3, 2, 6);
    chk("mid_x", 32'(a_x), 5);
    chk("mid_y", 32'(a_y), 2);
    run_to(3, 5, 12);
    chk("last_x", 32'(a_x), HA - 1);
    chk("last_y", 32'(a_y), VA - 1);
    chk("last_active", 32'(a_act), 1);
    chk("last_y_inv", 32'(b_y), VA - 1);
    run_to(3, 5, 13);
    chk("after_last_active", 32'(a_act), 0);
    chk("y_saturated", 32'(a_y), VA - 1);

    // stretched line: frame 4 row 3 is HT+1 clocks
    sf = 4; sr = 3;
    run_to(4, 4, 14);
    chk("stretch_pre_locked", 32'(a_lk), 1);
    chk("stretch_pre_mm", 32'(a_mm), 0);
    run_to(4, 4, 15);
    chk("stretch_mm", 32'(a_mm), 1);
    chk("stretch_unlock", 32'(a_lk), 0);
    chk("stretch_hor_total", 32'(a_ht), HT + 1);
    chk("stretch_mm_inv", 32'(b_mm), 1);
    run_to(4, 4, 16);
    chk("stretch_mm_1cyc", 32'(a_mm), 0);
    run_to(5, 7, 1);
    chk("relock_not_yet", 32'(a_lk), 0);
    run_to(6, 7, 0);
    chk("relock_before", 32'(a_lk), 0);
    run_to(6, 7, 1);
    chk("relock", 32'(a_lk), 1);
    chk("relock_inv", 32'(b_lk), 1);
    chk("stretch_mm_count", 32'(mm_seen), 1);

    // synchronous reset mid-frame
    run_to(7, 2, 6);
    chk("pre_rst_x", 32'(a_x), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_x", 32'(a_x), 0);
    chk("midrst_y", 32'(a_y), 0);
    chk("midrst_active", 32'(a_act), 0);
    chk("midrst_locked", 32'(a_lk), 0);
    chk("midrst_totals", 32'({a_ht, a_vt}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 50% clock enable from a fresh start
    ce_tog = 1'b1;
    sf = -1;
    restart_raster();
    run_to(2, 7, 0);
    chk("ce_lock_before", 32'(a_lk), 0);
    run_to(2, 7, 1);
    chk("ce_lock", 32'(a_lk), 1);
    chk("ce_hor_total", 32'(a_ht), HT);
    chk("ce_ver_total", 32'(a_vt), VT);
    chk("ce_frame_start_cleared", 32'(a_fs), 0);
    run_to(3, 0, 1);
    chk("ce_first_x", 32'(a_x), 0);
    chk("ce_first_y", 32'(a_y), 0);
    chk("ce_first_active", 32'(a_act), 1);
    run_to(3, 2, 6);
    chk("ce_mid_xy", 32'({a_x, a_y}), 32'({4'd5, 3'd2}));
    run_to(3, 5, 12);
    chk("ce_last_x", 32'(a_x), HA - 1);
    chk("ce_last_y", 32'(a_y), VA - 1);

    // hs held deasserted: hcnt saturates, one mismatch, back to SEARCH
    ce_tog = 1'b0;
    run_to(3, 9, 19);
    mm0 = mm_seen;
    hold_hs = 1'b1;
    run_to(4, 2, 19);
    hold_hs = 1'b0;
    run_to(4, 3, 15);
    chk("sat_mm_once", 32'(mm_seen - mm0), 1);
    chk("sat_unlocked", 32'(a_lk), 0);
    chk("sat_unlocked_inv", 32'(b_lk), 0);
    chk("sat_hor_total", 32'(a_ht), (1 << HTW) - 1);
`ifdef VIDEO_TIMING_DECODER_ERR_CNT_EN
    chk("err_count", 32'(a_ec), 1);
    chk("err_count_inv", 32'(b_ec), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
